// File: rtl/shift_sequencer_16b_pkg.sv
// Shared types and constants for the nibble/bit shift sequencer.
package shift_seq_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT4 = 2'd1,
    SHIFT1 = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Shift-amount width needed to express 0..width-1.
  function automatic int unsigned amt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_sequencer_16b_if.sv
// Request/result handshake bundle between requester and shift sequencer.
interface shift_sequencer_16b_if
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = amt_width(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/shift_sequencer_16b_step.sv
// One 4-bit slice of the left-shift chain: shifts by a whole nibble or by one bit.
module shift_step_4b
  import shift_seq_pkg::*;
(
  input  logic              sel_x4,
  input  logic [NIBBLE-1:0] d,
  input  logic [NIBBLE-1:0] cin,
  output logic [NIBBLE-1:0] q,
  output logic [NIBBLE-1:0] cout
);

  // In x1 mode only cin[0]/cout[0] carry the single bit crossing the slice.
  always_comb begin
    q    = {d[NIBBLE-2:0], cin[0]};
    cout = {(NIBBLE-1)'(0), d[NIBBLE-1]};
    if (sel_x4) begin
      q    = cin;
      cout = d;
    end
  end

endmodule

// File: rtl/shift_sequencer_16b.sv
// Multi-cycle variable left shifter: nibble steps then bit steps, one per clock.
// Define SHIFT_SEQ_ROTATE_EN to rotate instead of zero-filling (out_ovf then stays 0).
module shift_sequencer_16b
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = amt_width(WIDTH)
)(
  input  logic                  clk,
  input  logic                  rst_n,
  shift_sequencer_16b_if.slave  bus,
  output logic                  busy
);

  localparam int unsigned NSL  = WIDTH / NIBBLE;
  localparam int unsigned N4_W = AMT_W - 2;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] shifted;
  logic             ovf_q;
  logic             step_ovf;
  logic [N4_W-1:0]  n4_q;
  logic [1:0]       n1_q;
  logic             sel_x4;

  logic [NIBBLE-1:0] cin_w  [NSL];
  logic [NIBBLE-1:0] cout_w [NSL];

  assign sel_x4 = (state_q == SHIFT4);

  // Slice chain, LSB slice first; each slice's carry feeds the next one up.
  for (genvar i = 0; i < NSL; i++) begin : g_slice
    if (i > 0) begin : g_chain
      assign cin_w[i] = cout_w[i-1];
    end
    shift_step_4b u_step (
      .sel_x4 (sel_x4),
      .d      (data_q[i*NIBBLE +: NIBBLE]),
      .cin    (cin_w[i]),
      .q      (shifted[i*NIBBLE +: NIBBLE]),
      .cout   (cout_w[i])
    );
  end

`ifdef SHIFT_SEQ_ROTATE_EN
  assign cin_w[0] = cout_w[NSL-1];
  assign step_ovf = 1'b0;
`else
  assign cin_w[0] = '0;
  assign step_ovf = |cout_w[NSL-1];
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_ovf   = ovf_q;
  assign busy          = (state_q != IDLE);

  // Sequencer: load on accept, step nibbles then bits, hold result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      n4_q    <= '0;
      n1_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            data_q <= bus.in_data;
            n4_q   <= bus.in_amt[AMT_W-1:2];
            n1_q   <= bus.in_amt[1:0];
            ovf_q  <= 1'b0;
            if (bus.in_amt[AMT_W-1:2] != '0)  state_q <= SHIFT4;
            else if (bus.in_amt[1:0] != '0)   state_q <= SHIFT1;
            else                              state_q <= DONE;
          end
        end
        SHIFT4: begin
          data_q <= shifted;
          ovf_q  <= ovf_q | step_ovf;
          n4_q   <= n4_q - N4_W'(1);
          if (n4_q == N4_W'(1)) state_q <= (n1_q != 2'd0) ? SHIFT1 : DONE;
        end
        SHIFT1: begin
          data_q <= shifted;
          ovf_q  <= ovf_q | step_ovf;
          n1_q   <= n1_q - 2'd1;
          if (n1_q == 2'd1) state_q <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer_16b.sv
// Directed and table-driven bench for shift_sequencer_16b.
module tb_shift_sequencer_16b;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  shift_sequencer_16b_if #(.WIDTH(16)) bus ();

  shift_sequencer_16b #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  amt;
    logic [15:0] exp_data;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accept edge until out_valid shows up.
  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid never rose within %0d cycles", tag, lat);
    end
  endtask

  task automatic ref_model(input logic [15:0] d, input logic [3:0] a,
                           output logic [15:0] r, output logic o);
    logic [31:0] wide;
    wide = {16'h0, d} << a;
`ifdef SHIFT_SEQ_ROTATE_EN
    r = wide[15:0] | wide[31:16];
    o = 1'b0;
`else
    r = wide[15:0];
    o = (wide[31:16] != 16'h0);
`endif
  endtask

  // Single operation with out_ready held high.
  task automatic do_op(input vec_t v, input string tag);
    int lat;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = v.data;
    bus.in_amt   = v.amt;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = ~v.data;
    bus.in_amt   = ~v.amt;
    wait_valid(tag, lat);
    check({tag, "_lat"},  32'(lat), 32'(v.exp_lat));
    check({tag, "_data"}, 32'(bus.out_data), 32'(v.exp_data));
    check({tag, "_ovf"},  32'(bus.out_ovf), 32'(v.exp_ovf));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_idle"}, 32'({bus.out_valid, busy, bus.in_ready}), 32'b001);
  endtask

  initial begin
    int          lat;
    logic [15:0] rd;
    logic        ro;
    logic [15:0] held;
    vec_t        v;

`ifdef SHIFT_SEQ_ROTATE_EN
    vecs[0] = '{16'h1234, 4'd5,  16'h4682, 1'b0, 2};
    vecs[1] = '{16'h0ABC, 4'd0,  16'h0ABC, 1'b0, 0};
    vecs[2] = '{16'h0001, 4'd15, 16'h8000, 1'b0, 6};
    vecs[3] = '{16'h0003, 4'd15, 16'h8001, 1'b0, 6};
    vecs[4] = '{16'hF00F, 4'd4,  16'h00FF, 1'b0, 1};
    vecs[5] = '{16'h8001, 4'd1,  16'h0003, 1'b0, 1};
    vecs[6] = '{16'h00FF, 4'd8,  16'hFF00, 1'b0, 2};
    vecs[7] = '{16'h0F0F, 4'd3,  16'h7878, 1'b0, 3};
    vecs[8] = '{16'hA5A5, 4'd12, 16'h5A5A, 1'b0, 3};
`else
    vecs[0] = '{16'h1234, 4'd5,  16'h4680, 1'b1, 2};
    vecs[1] = '{16'h0ABC, 4'd0,  16'h0ABC, 1'b0, 0};
    vecs[2] = '{16'h0001, 4'd15, 16'h8000, 1'b0, 6};
    vecs[3] = '{16'h0003, 4'd15, 16'h8000, 1'b1, 6};
    vecs[4] = '{16'hF00F, 4'd4,  16'h00F0, 1'b1, 1};
    vecs[5] = '{16'h8001, 4'd1,  16'h0002, 1'b1, 1};
    vecs[6] = '{16'h00FF, 4'd8,  16'hFF00, 1'b0, 2};
    vecs[7] = '{16'h0F0F, 4'd3,  16'h7878, 1'b0, 3};
    vecs[8] = '{16'hA5A5, 4'd12, 16'h5000, 1'b1, 3};
`endif

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0;
    bus.in_amt    = 4'd0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data",  32'(bus.out_data),  32'd0);
    check("reset_out_ovf",   32'(bus.out_ovf),   32'd0);
    check("reset_busy",      32'(busy),          32'd0);
    check("reset_in_ready",  32'(bus.in_ready),  32'd1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a long shift drops the operation.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    bus.in_amt   = 4'd15;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data",  32'(bus.out_data),  32'd0);
    check("midrst_busy",      32'(busy),          32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst_no_valid",  32'(bus.out_valid), 32'd0);

    // Backpressure in DONE while a new request waits.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1234;
    bus.in_amt    = 4'd5;
    tick();
    bus.in_valid = 1'b0;
    wait_valid("bp", lat);
    check("bp_lat", 32'(lat), 32'd2);
    held = bus.out_data;
    check("bp_data", 32'(held), 32'(vecs[0].exp_data));
    bus.in_valid = 1'b1;
    bus.in_amt   = 4'd8;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = (i % 2 == 0) ? 16'h00FF : 16'hFF00;
      tick();
      check($sformatf("bp_hold%0d", i),
            32'({bus.out_valid, bus.in_ready, bus.out_data}), 32'({1'b1, 1'b0, held}));
    end
    bus.in_data   = 16'h00FF;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_idle", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    tick();
    bus.in_valid = 1'b0;
    check("bp_accept_busy", 32'({busy, bus.in_ready}), 32'b10);
    wait_valid("bp2", lat);
    check("bp2_lat",  32'(lat), 32'd2);
    check("bp2_data", 32'(bus.out_data), 32'hFF00);
    check("bp2_ovf",  32'(bus.out_ovf), 32'd0);
    tick();

    // Back-to-back random requests with random consumer stalls.
    for (int n = 0; n < 20; n++) begin
      v.data = 16'($urandom());
      v.amt  = 4'($urandom_range(0, 15));
      ref_model(v.data, v.amt, rd, ro);
      check($sformatf("rnd%0d_in_ready", n), 32'(bus.in_ready), 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_data   = v.data;
      bus.in_amt    = v.amt;
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = 16'($urandom());
      wait_valid($sformatf("rnd%0d", n), lat);
      check($sformatf("rnd%0d_lat", n),  32'(lat), 32'(v.amt[3:2]) + 32'(v.amt[1:0]));
      check($sformatf("rnd%0d_data", n), 32'(bus.out_data), 32'(rd));
      check($sformatf("rnd%0d_ovf", n),  32'(bus.out_ovf), 32'(ro));
      for (int k = 0; k < 12; k++) begin
        bus.out_ready = (k >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        if (bus.out_ready) break;
        check($sformatf("rnd%0d_stall%0d", n, k), 32'({bus.out_valid, bus.out_data}),
              32'({1'b1, rd}));
      end
      check($sformatf("rnd%0d_done", n), 32'({bus.out_valid, bus.in_ready}), 32'b01);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer_16b.md
Name: shift_sequencer_16b

Overview:
- Multi-cycle controller that sequences a chained 4-bit left-shift datapath to shift a WIDTH-bit word by a variable amount.
- Decomposes the shift amount into whole-nibble steps (x4) followed by single-bit steps (x1), one step per clock.
- Sits between an ALU-style requester (valid/ready in) and a result consumer (valid/ready out).
- Reports whether any 1 bit was shifted out (overflow).

Parameters:
- WIDTH, 16, data width in bits; must be a multiple of 4 and at least 8.
- AMT_W, 4, shift-amount width; derived as clog2(WIDTH) and not intended for override.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready at an edge
- in_data  input  WIDTH  operand
- in_amt  input  AMT_W  shift amount, 0..WIDTH-1
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result
- out_ovf  output  1  at least one 1 bit shifted out (zero-fill mode only)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, out_data=0, out_ovf=0, out_valid=0, busy=0. Reset wins over every other event, including mid-shift and DONE-awaiting-ready. Any operation in flight is dropped silently.
- in_ready = (state==IDLE). It is combinational from state only and never depends on in_valid.
- States:
  - IDLE: on accept, load data register with in_data, load N4=in_amt[AMT_W-1:2] and N1=in_amt[1:0], clear ovf. Next state is SHIFT4 if N4!=0, else SHIFT1 if N1!=0, else DONE.
  - SHIFT4: each edge, data <<= 4 with zero fill, ovf |= OR of the 4 bits shifted out, N4 decrements. When N4 reaches 1, the next state is SHIFT1 if N1!=0, else DONE.
  - SHIFT1: each edge, data <<= 1, ovf |= the bit shifted out, N1 decrements. When N1 reaches 1, the next state is DONE.
  - DONE: out_valid=1, out_data/out_ovf held stable. When out_ready is high at an edge, the next state is IDLE. out_valid never drops without a handshake.
- Latency: with N=N4+N1 and the accept edge E0, out_valid is high starting at edge E0+N. For in_amt=0, out_valid is high in the cycle after accept. The maximum is N=6 for in_amt=15 at WIDTH=16.
- Throughput: one operation per N+2 cycles minimum. There is no accept in the same cycle as the DONE->IDLE handshake.
- in_data and in_amt are sampled only at accept; later changes are ignored.
- in_valid while busy is ignored, with no error flag.
- out_data is also visible during SHIFT states as the intermediate value, but is qualified only by out_valid.
- Arithmetic: shifts are logical, zero-fill from the LSB. Result width is exactly WIDTH; there is no widening.

Optional Feature:
- Macro SHIFT_SEQ_ROTATE_EN.
  - Defined: the shift steps rotate instead of zero-fill (bits leaving the MSB re-enter at the LSB, 4 bits per SHIFT4 step, 1 per SHIFT1 step). out_ovf is tied to 0. Latency is unchanged.
  - Undefined: logical zero-fill left shift, and out_ovf behaves as above.

Decomposition:
- Shared package shift_seq_pkg:
  - state enum {IDLE, SHIFT4, SHIFT1, DONE}, 2-bit encoding
  - localparam NIBBLE=4
  - function computing AMT_W from WIDTH
- Sub-module shift_step_4b: one 4-bit slice with a step-select input (x4 / x1) and carry-in/carry-out. It is instantiated WIDTH/4 times, chained LSB slice to MSB slice. The MSB slice's carry-out feeds the ovf logic, or the LSB carry-in when SHIFT_SEQ_ROTATE_EN is defined.
- FSM, counters and handshake stay in the top module.

Test Plan:
- Reset mid-shift: accept 0xFFFF amt 15, assert rst_n low at cycle 3 -> state IDLE, out_valid=0, out_data=0, in_ready=1 the cycle after rst_n returns high.
- in_data=0x1234, in_amt=5, out_ready=1 -> out_valid at E0+2, out_data=0x4680, out_ovf=1. With SHIFT_SEQ_ROTATE_EN: out_data=0x4682, out_ovf=0.
- in_data=0x0ABC, in_amt=0 -> out_valid in the cycle after accept, out_data=0x0ABC, out_ovf=0, busy high for exactly 1 cycle.
- in_data=0x0001, in_amt=15 -> out_valid at E0+6, out_data=0x8000, out_ovf=0. Then in_data=0x0003, amt 15 -> out_data=0x8000, out_ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and new data toggling -> out_valid/out_data stable, in_ready=0, no second accept. Release out_ready -> IDLE next cycle, then the new request is accepted.
- Back-to-back: 20 random (data, amt) requests with random out_ready -> every result matches the reference model ((data<<amt) & 0xFFFF, ovf = (data>>(16-amt))!=0 for amt>0, else 0), and each latency equals amt[3:2]+amt[1:0].
